// File: rtl/decode_stage.sv
// decode_stage: consumer end of the fetch interface. Holds the IF/ID register,
// the 32x32 register file, a RUN/STALL load-use FSM and decode-time resolution
// of beq/bne/j/jal, and produces the registered ID/EX operand set.
// Optional feature: define DECODE_STALL_COUNT_EN to enable the saturating
// load-use stall counter on stall_count_out (tied to zero otherwise).
module decode_stage #(
  parameter int BUNDLE_W = 27,
  parameter int LOAD_BIT = 2,
  parameter int WE_BIT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instruction_in,
  input  logic [BUNDLE_W-1:0] bundle_in,
  input  logic [31:0]         pc4_in,
  input  logic                wb_we_in,
  input  logic [4:0]          wb_addr_in,
  input  logic [31:0]         wb_data_in,
  output logic                stall_out,
  output logic                redirect_out,
  output logic [31:0]         redirect_pc_out,
  output logic                ex_valid_out,
  output logic [31:0]         ex_rs_data_out,
  output logic [31:0]         ex_rt_data_out,
  output logic [31:0]         ex_imm_out,
  output logic [4:0]          ex_dest_out,
  output logic [BUNDLE_W-1:0] ex_bundle_out,
  output logic [31:0]         ex_pc4_out,
  output logic [31:0]         stall_count_out
);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;

  state_t              state;
  logic                ifid_valid;
  logic [31:0]         ifid_instr;
  logic [31:0]         ifid_pc4;
  logic [BUNDLE_W-1:0] ifid_bundle;
  logic [31:0]         regs [32];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_sext;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic [31:0] rt_issue;
  logic [4:0]  dest;
  logic        hazard;
  logic        take;
  logic        unused_we_bit;

  assign opcode        = ifid_instr[31:26];
  assign rs            = ifid_instr[25:21];
  assign rt            = ifid_instr[20:16];
  assign rd            = ifid_instr[15:11];
  assign imm_sext      = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
  assign branch_target = ifid_pc4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

  // The write-enable bit travels in the bundle; decode itself never acts on it.
  assign unused_we_bit = ifid_bundle[WE_BIT];

  // Register read ports: r0 reads zero, a same-cycle writeback is bypassed.
  always_comb begin
    rs_data = 32'd0;
    rt_data = 32'd0;
    if (rs == 5'd0) begin
      rs_data = 32'd0;
    end else if (wb_we_in && (wb_addr_in == rs)) begin
      rs_data = wb_data_in;
    end else begin
      rs_data = regs[rs];
    end
    if (rt == 5'd0) begin
      rt_data = 32'd0;
    end else if (wb_we_in && (wb_addr_in == rt)) begin
      rt_data = wb_data_in;
    end else begin
      rt_data = regs[rt];
    end
  end

  // Load-use detection and branch/jump resolution for the IF/ID instruction.
  always_comb begin
    hazard = 1'b0;
    take   = 1'b0;
    target = 32'd0;
    if ((state == RUN) && ifid_valid) begin
      hazard = ex_valid_out && ex_bundle_out[LOAD_BIT] && (ex_dest_out != 5'd0) &&
               ((ex_dest_out == rs) || (ex_dest_out == rt));
      if (!hazard) begin
        case (opcode)
          OP_BEQ: begin
            take   = (rs_data == rt_data);
            target = branch_target;
          end
          OP_BNE: begin
            take   = (rs_data != rt_data);
            target = branch_target;
          end
          OP_J, OP_JAL: begin
            take   = 1'b1;
            target = jump_target;
          end
          default: begin
            take   = 1'b0;
            target = 32'd0;
          end
        endcase
      end else begin
        take   = 1'b0;
        target = 32'd0;
      end
    end else begin
      hazard = 1'b0;
      take   = 1'b0;
    end
  end

  assign stall_out       = hazard;
  assign redirect_out    = take;
  assign redirect_pc_out = take ? target : 32'd0;

  // Destination select and jal link-value substitution for the issued operands.
  always_comb begin
    dest     = rt;
    rt_issue = rt_data;
    case (opcode)
      OP_RTYPE: begin
        dest     = rd;
        rt_issue = rt_data;
      end
      OP_JAL: begin
        dest     = 5'd31;
        rt_issue = ifid_pc4;
      end
      default: begin
        dest     = rt;
        rt_issue = rt_data;
      end
    endcase
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_we_in && (wb_addr_in != 5'd0)) begin
      regs[wb_addr_in] <= wb_data_in;
    end
  end

  // RUN/STALL FSM, IF/ID capture/hold/flush and ID/EX issue or bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= RUN;
      ifid_valid     <= 1'b0;
      ifid_instr     <= 32'd0;
      ifid_pc4       <= 32'd0;
      ifid_bundle    <= {BUNDLE_W{1'b0}};
      ex_valid_out   <= 1'b0;
      ex_rs_data_out <= 32'd0;
      ex_rt_data_out <= 32'd0;
      ex_imm_out     <= 32'd0;
      ex_dest_out    <= 5'd0;
      ex_bundle_out  <= {BUNDLE_W{1'b0}};
      ex_pc4_out     <= 32'd0;
    end else begin
      case (state)
        RUN:     state <= hazard ? STALL : RUN;
        STALL:   state <= RUN;
        default: state <= RUN;
      endcase

      // A stalled IF/ID keeps its instruction; a redirect squashes the fall-through fetch.
      if (!hazard) begin
        if (take) begin
          ifid_valid  <= 1'b0;
          ifid_instr  <= 32'd0;
          ifid_pc4    <= 32'd0;
          ifid_bundle <= {BUNDLE_W{1'b0}};
        end else begin
          ifid_valid  <= 1'b1;
          ifid_instr  <= instruction_in;
          ifid_pc4    <= pc4_in;
          ifid_bundle <= bundle_in;
        end
      end

      if (hazard) begin
        ex_valid_out   <= 1'b0;
        ex_rs_data_out <= 32'd0;
        ex_rt_data_out <= 32'd0;
        ex_imm_out     <= 32'd0;
        ex_dest_out    <= 5'd0;
        ex_bundle_out  <= {BUNDLE_W{1'b0}};
        ex_pc4_out     <= 32'd0;
      end else begin
        ex_valid_out   <= ifid_valid;
        ex_rs_data_out <= rs_data;
        ex_rt_data_out <= rt_issue;
        ex_imm_out     <= imm_sext;
        ex_dest_out    <= dest;
        ex_bundle_out  <= ifid_bundle;
        ex_pc4_out     <= ifid_pc4;
      end
    end
  end

`ifdef DECODE_STALL_COUNT_EN
  logic [31:0] stall_count;

  // Saturating count of cycles spent in a load-use stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= 32'd0;
    end else if (hazard && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign stall_count_out = stall_count;
`else
  assign stall_count_out = 32'd0;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch interface: accepts instruction, control bundle and pc+4 from the fetch stage each cycle.
- Holds the IF/ID pipeline register and the 32x32 register file, and produces the registered ID/EX operand set.
- Drives stall and redirect back to fetch: load-use stalls, and beq/bne/j/jal resolved in decode.

Parameters:
- BUNDLE_W, 27, control bundle width.
- LOAD_BIT, 2, bundle bit index meaning data_mem_re (load).
- WE_BIT, 0, bundle bit index meaning regfile_we.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- instruction_in  in  32  instruction from fetch.
- bundle_in  in  BUNDLE_W  control bundle from fetch.
- pc4_in  in  32  fetch pc+4 of instruction_in.
- wb_we_in  in  1  writeback write enable.
- wb_addr_in  in  5  writeback register index.
- wb_data_in  in  32  writeback data.
- stall_out  out  1  fetch must hold its PC this cycle.
- redirect_out  out  1  fetch must load redirect_pc_out.
- redirect_pc_out  out  32  branch/jump target.
- ex_valid_out  out  1  ID/EX holds a real instruction.
- ex_rs_data_out  out  32  rs operand.
- ex_rt_data_out  out  32  rt operand.
- ex_imm_out  out  32  sign-extended instruction[15:0].
- ex_dest_out  out  5  destination: rd for opcode 0, 31 for jal, rt otherwise.
- ex_bundle_out  out  BUNDLE_W  bundle passed through.
- ex_pc4_out  out  32  pc+4 passed through.
- stall_count_out  out  32  load-use stall counter (optional feature).

Behaviour:
- Reset (reset==0 at posedge): IF/ID cleared to NOP (instruction 0, bundle 0, valid 0); all ex_* outputs 0; all 32 registers 0; FSM to RUN; stall_count 0.
- Reset mid-stall or mid-redirect: the pending operation is discarded.
- IF/ID capture: at each posedge, loads instruction_in, bundle_in and pc4_in unless stalled (holds) or flushed (loads NOP, valid 0).
- Register file:
  - Two combinational read ports (rs=[25:21], rt=[20:16]) and one write port at posedge when wb_we_in && wb_addr_in!=0.
  - Register r0 always reads 0.
  - Same-cycle write/read of the same index returns wb_data_in (bypass).
- FSM states:
  - RUN: hazard = ex_valid_out && ex_bundle_out[LOAD_BIT] && ex_dest_out!=0 && (ex_dest_out==rs || ex_dest_out==rt), for a valid IF/ID instruction.
    - If hazard: stall_out=1, IF/ID holds, ID/EX loads a bubble (valid 0, bundle 0), next state STALL.
    - Otherwise: ID/EX loads the decoded instruction.
  - STALL: stall_out=0, ID/EX loads the held instruction (the load is now past EX), next state RUN. Exactly one bubble per load-use.
- Branch/jump, evaluated in RUN with no hazard and IF/ID valid; the combinational redirect_out asserts:
  - opcode 4 (beq): when rs==rt (post-bypass values).
  - opcode 5 (bne): when rs!=rt.
  - Target for beq/bne = pc4 + (sext(imm16)<<2), 32-bit wrap-around.
  - opcode 2/3 (j/jal): always; target {pc4[31:28], instr[25:0], 2'b00}.
  - jal: ex_rt_data_out = pc4 (link value).
  - When redirect_out=1: the instruction is still issued to ID/EX, and IF/ID is flushed at the same edge. There is no delay slot.
- redirect_out is never asserted while stall_out=1.
- redirect_pc_out is 0 when redirect_out=0.
- Latency: an instruction accepted at edge N appears on ex_* after edge N+1, or N+2 when stalled.

Optional Feature:
- Macro DECODE_STALL_COUNT_EN.
- Defined: stall_count_out increments by 1 on each edge where stall_out=1, saturating at 0xFFFFFFFF; cleared on reset.
- Undefined: no counter logic; stall_count_out tied to 0.

Test Plan:
- Reset low with IF/ID and registers dirty -> after one edge, all ex_* 0, stall_out 0, redirect_out 0, reads of r1..r31 return 0.
- WB writes r5=0x1234 while decode reads rs=r5 in the same cycle -> ex_rs_data_out=0x1234 next edge; a write to r0 leaves r0 reading 0.
- lw r8 followed by add r9,r8,r2 -> stall_out=1 for exactly one cycle, one ex_valid_out=0 bubble, then the add issues with r8 as dest match. With DECODE_STALL_COUNT_EN, stall_count_out=1.
- beq r1,r2,+3 with pc4=0x100 and r1==r2 -> redirect_out=1, redirect_pc_out=0x10C, next IF/ID is NOP. With r1!=r2, no redirect.
- jal 0x0000040 at pc4=0x90000004 -> redirect_pc_out=0x90000100, ex_dest_out=31, ex_rt_data_out=0x90000004.
- Reset asserted during STALL -> FSM returns to RUN, the held instruction is dropped, stall_out=0.
